// File: rtl/hazard_pkg.sv
// hazard_pkg: shared widths, counter type and helpers for the ID hazard scoreboard
package hazard_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int WB_DIST    = 3;
  localparam int CNT_W      = 2;

  typedef logic [CNT_W-1:0] sb_cnt_t;

  function automatic logic is_x0(input logic [REG_ADDR_W-1:0] a);
    return a == '0;
  endfunction
endpackage

// File: rtl/sb_entry.sv
// sb_entry: per-register countdown of cycles until the in-flight write reaches WB
module sb_entry
  import hazard_pkg::*;
(
  input  logic    i_clk,
  input  logic    i_rst_n,
  input  logic    i_set,
  output sb_cnt_t o_cnt,
  output logic    o_busy
);
  sb_cnt_t r_cnt;

  // A new producer reloads the distance (overriding any older one); otherwise count down to zero
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_cnt <= '0;
    else if (i_set) r_cnt <= sb_cnt_t'(WB_DIST);
    else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;

  assign o_cnt  = r_cnt;
  assign o_busy = r_cnt != '0;
endmodule

// File: rtl/id_hazard_scoreboard.sv
// id_hazard_scoreboard: decode-stage RAW stall and redirect flush control for a non-forwarding pipeline
// Optional macro RF_WRITE_THROUGH_EN: register file bypasses the WB write to a same-cycle read,
// so a producer sitting in WB no longer blocks its consumer.
module id_hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid_d,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr,
  input  logic                  i_rs1_used,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr,
  input  logic                  i_rs2_used,
  input  logic [REG_ADDR_W-1:0] i_rd_addr,
  input  logic                  i_rd_we,
  input  logic                  i_redirect_e,
  output logic                  o_stall_f,
  output logic                  o_stall_d,
  output logic                  o_flush_d,
  output logic                  o_bubble_e,
  output logic [NREG-1:0]       o_busy
);
  sb_cnt_t         w_cnt [NREG];
  logic [NREG-1:0] w_busy;
  logic            w_haz1, w_haz2, w_raw, w_issue;

  function automatic logic blocked(input sb_cnt_t c);
`ifdef RF_WRITE_THROUGH_EN
    return c >= sb_cnt_t'(2);
`else
    return c != '0;
`endif
  endfunction

  assign w_cnt[0]  = '0;
  assign w_busy[0] = 1'b0;

  for (genvar g = 1; g < NREG; g++) begin : g_ent
    sb_entry u_entry (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_set  (w_issue && (i_rd_addr == REG_ADDR_W'(g))),
      .o_cnt  (w_cnt[g]),
      .o_busy (w_busy[g])
    );
  end

  // Hazard detection and pipeline controls; a redirect kills the ID instruction so it never stalls
  always_comb begin
    w_haz1     = i_valid_d && i_rs1_used && !is_x0(i_rs1_addr) && blocked(w_cnt[i_rs1_addr]);
    w_haz2     = i_valid_d && i_rs2_used && !is_x0(i_rs2_addr) && blocked(w_cnt[i_rs2_addr]);
    w_raw      = w_haz1 || w_haz2;
    w_issue    = i_valid_d && !w_raw && !i_redirect_e && i_rd_we && !is_x0(i_rd_addr);
    o_flush_d  = i_redirect_e;
    o_stall_d  = w_raw && !i_redirect_e;
    o_stall_f  = w_raw && !i_redirect_e;
    o_bubble_e = i_redirect_e || w_raw;
  end

  assign o_busy = w_busy;
endmodule
